// File: rtl/adc_pingpong_sample_bank_pkg.sv
// Shared defaults and state encoding for the ADC ping-pong sample bank.
// The sample geometry defaults are common with the Goertzel blocks.
package adc_pingpong_sample_bank_pkg;

    localparam int DEF_SAMPLE_W    = 8;
    localparam int DEF_SAMPLE_BITS = 9;
    localparam int DEF_NUM_SAMPLES = 512;
    localparam int DEF_DROP_W      = 16;

    // FILL: the write bank accepts samples.
    // FULL_WAIT: the write bank is full and the consumer still holds the read bank.
    typedef enum logic {
        FILL      = 1'b0,
        FULL_WAIT = 1'b1
    } bank_state_t;

endpackage

// File: rtl/adc_pingpong_sample_bank_if.sv
// Sample-stream, read-port and status signals of the ping-pong sample bank.
// The master is the ADC/consumer side; the slave is the bank itself.
interface adc_pingpong_sample_bank_if #(
    parameter int SAMPLE_W    = 8,
    parameter int SAMPLE_BITS = 9,
    parameter int DROP_W      = 16
);
    logic                   sample_valid;
    logic [SAMPLE_W-1:0]    sample_data;
    logic [SAMPLE_BITS-1:0] rd_addr;
    logic [SAMPLE_W-1:0]    rd_data;
    logic                   rd_lock;
    logic                   overrun_clr;
    logic                   bank_switch;
    logic                   bank_ready;
    logic                   overrun;
    logic [DROP_W-1:0]      drop_count;

    modport master (
        output sample_valid, sample_data, rd_addr, rd_lock, overrun_clr,
        input  rd_data, bank_switch, bank_ready, overrun, drop_count
    );

    modport slave (
        input  sample_valid, sample_data, rd_addr, rd_lock, overrun_clr,
        output rd_data, bank_switch, bank_ready, overrun, drop_count
    );
endinterface

// File: rtl/adc_pingpong_sample_bank_ram.sv
// Simple dual-port sample store holding both banks; address = {bank, ptr}.
// Synchronous write, registered synchronous read (maps onto iCE40 EBR).
module adc_pingpong_sample_bank_ram #(
    parameter int SAMPLE_W = 8,
    parameter int ADDR_W   = 10
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [SAMPLE_W-1:0] mem [DEPTH];

    // Write port: store one sample per enabled cycle.
    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: one-cycle registered read; the output register clears on reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/adc_pingpong_sample_bank.sv
// Ping-pong capture store between the ADC stream and the Goertzel engine.
// Samples fill the write bank while the consumer reads the other bank;
// a full write bank swaps roles and toggles bank_switch as the start trigger.
module adc_pingpong_sample_bank
    import adc_pingpong_sample_bank_pkg::*;
#(
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int DECIM       = 1,
    parameter bit SIGNED_OUT  = 1'b1,
    parameter int DROP_W      = DEF_DROP_W
) (
    input logic                       sys_clk,
    input logic                       rst,
    adc_pingpong_sample_bank_if.slave bus
);
    localparam logic [SAMPLE_BITS-1:0] LAST_PTR   = SAMPLE_BITS'(NUM_SAMPLES - 1);
    localparam logic [7:0]             DECIM_LAST = 8'(DECIM - 1);
    // Flipping the MSB turns offset-binary ADC codes into two's complement.
    localparam logic [SAMPLE_W-1:0]    MSB_MASK   =
        SIGNED_OUT ? {1'b1, {(SAMPLE_W-1){1'b0}}} : '0;

    bank_state_t            state;
    bank_state_t            state_next;
    logic                   wr_bank;
    logic [SAMPLE_BITS-1:0] wr_ptr;
    logic [7:0]             decim_cnt;
    logic                   accept;
    logic                   mem_we;
    logic                   ptr_inc;
    logic                   do_swap;
    logic                   do_drop;
    logic                   bank_switch;
    logic                   bank_ready;
    logic                   overrun;
    logic [DROP_W-1:0]      drop_count;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept = bus.sample_valid && (decim_cnt == 8'd0);

    // State register for the fill / full-wait controller.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle actions: write, advance, swap or drop.
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        ptr_inc    = 1'b0;
        do_swap    = 1'b0;
        do_drop    = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    mem_we = 1'b1;
                    if (wr_ptr != LAST_PTR) begin
                        ptr_inc = 1'b1;
                    end else if (!bus.rd_lock) begin
                        do_swap = 1'b1;
                    end else begin
                        state_next = FULL_WAIT;
                    end
                end
            end
            FULL_WAIT: begin
                // Nothing is written while waiting, including a sample that
                // lands on the release cycle.
                if (accept) begin
                    do_drop = 1'b1;
                end
                if (!bus.rd_lock) begin
                    do_swap    = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Bank/pointer bookkeeping, decimation counter and sticky status.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_bank     <= 1'b0;
            wr_ptr      <= '0;
            decim_cnt   <= '0;
            bank_switch <= 1'b0;
            bank_ready  <= 1'b0;
            overrun     <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (bus.sample_valid) begin
                decim_cnt <= (decim_cnt == DECIM_LAST) ? 8'd0 : decim_cnt + 8'd1;
            end
            if (do_swap) begin
                wr_bank     <= ~wr_bank;
                wr_ptr      <= '0;
                bank_switch <= ~bank_switch;
                bank_ready  <= 1'b1;
            end else if (ptr_inc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (do_drop) begin
                overrun    <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end else if (bus.overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    adc_pingpong_sample_bank_ram #(
        .SAMPLE_W (SAMPLE_W),
        .ADDR_W   (SAMPLE_BITS + 1)
    ) u_ram (
        .sys_clk (sys_clk),
        .rst     (rst),
        .we      (mem_we),
        .wr_addr ({wr_bank, wr_ptr}),
        .wr_data (bus.sample_data ^ MSB_MASK),
        .rd_addr ({~wr_bank, bus.rd_addr}),
        .rd_data (bus.rd_data)
    );

    assign bus.bank_switch = bank_switch;
    assign bus.bank_ready  = bank_ready;
    assign bus.overrun     = overrun;
    assign bus.drop_count  = drop_count;
endmodule

// File: tb/tb_adc_pingpong_sample_bank.sv
// Directed bench for the ping-pong sample bank: one undecimated instance and
// one DECIM=4 instance, both storing two's-complement samples.
module tb_adc_pingpong_sample_bank;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    always #5 sys_clk = ~sys_clk;

    adc_pingpong_sample_bank_if #(.SAMPLE_W(8), .SAMPLE_BITS(9), .DROP_W(16)) bus0 ();
    adc_pingpong_sample_bank_if #(.SAMPLE_W(8), .SAMPLE_BITS(9), .DROP_W(16)) bus1 ();

    adc_pingpong_sample_bank #(
        .SAMPLE_W(8), .SAMPLE_BITS(9), .NUM_SAMPLES(512),
        .DECIM(1), .SIGNED_OUT(1'b1), .DROP_W(16)
    ) u_dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus0.slave)
    );

    adc_pingpong_sample_bank #(
        .SAMPLE_W(8), .SAMPLE_BITS(9), .NUM_SAMPLES(512),
        .DECIM(4), .SIGNED_OUT(1'b1), .DROP_W(16)
    ) u_dec (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus1.slave)
    );

    // Strobe n consecutive samples into instance 0, data = base + step*i.
    task automatic push0(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            bus0.sample_valid = 1'b1;
            bus0.sample_data  = 8'(base + step * i);
        end
        @(negedge sys_clk);
        bus0.sample_valid = 1'b0;
    endtask

    task automatic push1(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            bus1.sample_valid = 1'b1;
            bus1.sample_data  = 8'(base + i);
        end
        @(negedge sys_clk);
        bus1.sample_valid = 1'b0;
    endtask

    task automatic read0(input int addr, output logic [7:0] val);
        @(negedge sys_clk);
        bus0.rd_addr = 9'(addr);
        @(negedge sys_clk);
        val = bus0.rd_data;
    endtask

    task automatic read1(input int addr, output logic [7:0] val);
        @(negedge sys_clk);
        bus1.rd_addr = 9'(addr);
        @(negedge sys_clk);
        val = bus1.rd_data;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({bus0.rd_data, bus0.bank_switch, bus0.bank_ready, bus0.overrun, bus0.drop_count} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%h sw=%b rdy=%b ovr=%b drop=%0d, expected all 0",
                     bus0.rd_data, bus0.bank_switch, bus0.bank_ready, bus0.overrun, bus0.drop_count);
        end
        rst = 1'b0;
        push0(511, 0, 1);
        checks++;
        if (bus0.bank_switch !== 1'b0) begin
            errors++;
            $display("FAIL no_swap_511: bank_switch got %b expected 0", bus0.bank_switch);
        end
        push0(1, 511, 1);
        checks++;
        if (bus0.bank_switch !== 1'b1 || bus0.bank_ready !== 1'b1) begin
            errors++;
            $display("FAIL swap_512: got sw=%b rdy=%b expected sw=1 rdy=1",
                     bus0.bank_switch, bus0.bank_ready);
        end
    endtask

    // Bank 0 now holds i[7:0] ^ 0x80 at address i.
    task automatic test_write_read;
        @(negedge sys_clk);
        bus0.rd_addr = 9'd0;
        @(negedge sys_clk);
        checks++;
        if (bus0.rd_data !== 8'h80) begin
            errors++;
            $display("FAIL read_addr0: got %h expected 80", bus0.rd_data);
        end
        bus0.rd_addr = 9'd1;
        #1;
        checks++;
        if (bus0.rd_data !== 8'h80) begin
            errors++;
            $display("FAIL read_latency: got %h expected 80 (old data)", bus0.rd_data);
        end
        @(negedge sys_clk);
        checks++;
        if (bus0.rd_data !== 8'h81) begin
            errors++;
            $display("FAIL read_addr1: got %h expected 81", bus0.rd_data);
        end
        bus0.rd_addr = 9'd256;
        @(negedge sys_clk);
        checks++;
        if (bus0.rd_data !== 8'h80) begin
            errors++;
            $display("FAIL read_addr256: got %h expected 80", bus0.rd_data);
        end
        bus0.rd_addr = 9'd255;
        @(negedge sys_clk);
        checks++;
        if (bus0.rd_data !== 8'h7F) begin
            errors++;
            $display("FAIL read_addr255: got %h expected 7f", bus0.rd_data);
        end
        bus0.rd_addr = 9'd511;
        @(negedge sys_clk);
        checks++;
        if (bus0.rd_data !== 8'h7F) begin
            errors++;
            $display("FAIL read_addr511: got %h expected 7f", bus0.rd_data);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] v;
        bus0.rd_lock = 1'b1;
        push0(512, 8'h11, 0);
        push0(10, 8'hEE, 0);
        checks++;
        if (bus0.overrun !== 1'b1 || bus0.drop_count !== 16'd10 || bus0.bank_switch !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drop10: got ovr=%b drop=%0d sw=%b expected ovr=1 drop=10 sw=1",
                     bus0.overrun, bus0.drop_count, bus0.bank_switch);
        end
        // Clear with no drop pending.
        bus0.overrun_clr = 1'b1;
        @(negedge sys_clk);
        bus0.overrun_clr = 1'b0;
        checks++;
        if (bus0.overrun !== 1'b0 || bus0.drop_count !== 16'd10) begin
            errors++;
            $display("FAIL overrun_clr: got ovr=%b drop=%0d expected ovr=0 drop=10",
                     bus0.overrun, bus0.drop_count);
        end
        // Clear coincident with a drop: set wins.
        bus0.overrun_clr  = 1'b1;
        bus0.sample_valid = 1'b1;
        bus0.sample_data  = 8'hEE;
        @(negedge sys_clk);
        bus0.overrun_clr  = 1'b0;
        bus0.sample_valid = 1'b0;
        checks++;
        if (bus0.overrun !== 1'b1 || bus0.drop_count !== 16'd11) begin
            errors++;
            $display("FAIL clr_vs_drop: got ovr=%b drop=%0d expected ovr=1 drop=11",
                     bus0.overrun, bus0.drop_count);
        end
        // Release the lock with a sample on the same cycle: swap, sample dropped.
        bus0.rd_lock      = 1'b0;
        bus0.sample_valid = 1'b1;
        bus0.sample_data  = 8'hEE;
        @(negedge sys_clk);
        bus0.sample_valid = 1'b0;
        checks++;
        if (bus0.bank_switch !== 1'b0 || bus0.drop_count !== 16'd12) begin
            errors++;
            $display("FAIL release_swap: got sw=%b drop=%0d expected sw=0 drop=12",
                     bus0.bank_switch, bus0.drop_count);
        end
        read0(0, v);
        checks++;
        if (v !== 8'h91) begin
            errors++;
            $display("FAIL held_bank_addr0: got %h expected 91", v);
        end
        read0(511, v);
        checks++;
        if (v !== 8'h91) begin
            errors++;
            $display("FAIL held_bank_addr511: got %h expected 91", v);
        end
        push0(511, 8'h20, 1);
        checks++;
        if (bus0.bank_switch !== 1'b0) begin
            errors++;
            $display("FAIL refill_511: bank_switch got %b expected 0", bus0.bank_switch);
        end
        push0(1, 8'h20 + 511, 1);
        checks++;
        if (bus0.bank_switch !== 1'b1) begin
            errors++;
            $display("FAIL refill_512: bank_switch got %b expected 1", bus0.bank_switch);
        end
        read0(0, v);
        checks++;
        if (v !== 8'hA0) begin
            errors++;
            $display("FAIL refill_addr0: got %h expected a0", v);
        end
        read0(5, v);
        checks++;
        if (v !== 8'hA5) begin
            errors++;
            $display("FAIL refill_addr5: got %h expected a5", v);
        end
    endtask

    task automatic test_reset_mid_fill;
        logic [7:0] v;
        push0(300, 8'h33, 0);
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        checks++;
        if ({bus0.rd_data, bus0.bank_switch, bus0.bank_ready, bus0.overrun, bus0.drop_count} !== 35'd0) begin
            errors++;
            $display("FAIL midfill_reset: got rd=%h sw=%b rdy=%b ovr=%b drop=%0d, expected all 0",
                     bus0.rd_data, bus0.bank_switch, bus0.bank_ready, bus0.overrun, bus0.drop_count);
        end
        push0(511, 0, 1);
        checks++;
        if (bus0.bank_switch !== 1'b0) begin
            errors++;
            $display("FAIL midfill_511: bank_switch got %b expected 0", bus0.bank_switch);
        end
        push0(1, 511, 1);
        checks++;
        if (bus0.bank_switch !== 1'b1) begin
            errors++;
            $display("FAIL midfill_512: bank_switch got %b expected 1", bus0.bank_switch);
        end
        read0(0, v);
        checks++;
        if (v !== 8'h80) begin
            errors++;
            $display("FAIL midfill_addr0: got %h expected 80", v);
        end
        read0(300, v);
        checks++;
        if (v !== 8'hAC) begin
            errors++;
            $display("FAIL midfill_addr300: got %h expected ac", v);
        end
    endtask

    // Accepted strobes are 0,4,...,2044; the 512th accept is strobe 2044.
    task automatic test_decimation;
        logic [7:0] v;
        push1(2044, 0);
        checks++;
        if (bus1.bank_switch !== 1'b0) begin
            errors++;
            $display("FAIL decim_2044: bank_switch got %b expected 0", bus1.bank_switch);
        end
        push1(4, 2044);
        checks++;
        if (bus1.bank_switch !== 1'b1 || bus1.bank_ready !== 1'b1) begin
            errors++;
            $display("FAIL decim_2048: got sw=%b rdy=%b expected sw=1 rdy=1",
                     bus1.bank_switch, bus1.bank_ready);
        end
        read1(0, v);
        checks++;
        if (v !== 8'h80) begin
            errors++;
            $display("FAIL decim_addr0: got %h expected 80", v);
        end
        read1(1, v);
        checks++;
        if (v !== 8'h84) begin
            errors++;
            $display("FAIL decim_addr1: got %h expected 84", v);
        end
        read1(2, v);
        checks++;
        if (v !== 8'h88) begin
            errors++;
            $display("FAIL decim_addr2: got %h expected 88", v);
        end
        read1(511, v);
        checks++;
        if (v !== 8'h7C) begin
            errors++;
            $display("FAIL decim_addr511: got %h expected 7c", v);
        end
    endtask

    initial begin
        bus0.sample_valid = 1'b0;
        bus0.sample_data  = 8'h00;
        bus0.rd_addr      = 9'd0;
        bus0.rd_lock      = 1'b0;
        bus0.overrun_clr  = 1'b0;
        bus1.sample_valid = 1'b0;
        bus1.sample_data  = 8'h00;
        bus1.rd_addr      = 9'd0;
        bus1.rd_lock      = 1'b0;
        bus1.overrun_clr  = 1'b0;
        test_reset;
        test_write_read;
        test_overrun;
        test_reset_mid_fill;
        test_decimation;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
